// File: rtl/peak_pkg.sv
// Shared types, m_axis_tdata field layout and sample-magnitude helper for the
// windowed peak detector.
package peak_pkg;

  localparam int unsigned PEAK_W    = 32;
  localparam int unsigned IDX_W     = 24;
  localparam int unsigned CH_W      = 8;
  localparam int unsigned M_TDATA_W = 64;
  localparam int unsigned PEAK_LSB  = 0;
  localparam int unsigned IDX_LSB   = 32;
  localparam int unsigned CH_LSB    = 56;

  typedef struct packed {
    logic signed [PEAK_W-1:0] peak;
    logic [IDX_W-1:0]         idx;
  } peak_rec_t;

  // Compare key for a sign-extended w-bit sample; the most negative code saturates in abs mode.
  function automatic logic signed [PEAK_W-1:0] mag(input logic signed [PEAK_W-1:0] s,
                                                   input int unsigned w,
                                                   input logic abs_mode);
    logic signed [PEAK_W-1:0] top;
    logic signed [PEAK_W-1:0] min_v;
    logic signed [PEAK_W-1:0] r;
    top   = {1'b1, {(PEAK_W-1){1'b0}}};
    min_v = top >>> (PEAK_W - w);
    r     = s;
    if (abs_mode) begin
      if (s == min_v) r = ~min_v;
      else if (s < 0) r = -s;
    end
    return r;
  endfunction

  function automatic logic [M_TDATA_W-1:0] pack_beat(input peak_rec_t r, input logic [CH_W-1:0] ch);
    logic [M_TDATA_W-1:0] b;
    b = '0;
    b[PEAK_LSB +: PEAK_W] = r.peak;
    b[IDX_LSB +: IDX_W]   = r.idx;
    b[CH_LSB +: CH_W]     = ch;
    return b;
  endfunction

endpackage

// File: rtl/peak_lane_tracker.sv
// Per-channel peak/index register; exposes its next value so a window-ending
// beat can be captured on the same edge it is compared.
module peak_lane_tracker
  import peak_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned ABS_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [IDX_W-1:0]    frame_idx,
  output peak_rec_t           rec_d_c
);

  peak_rec_t                rec_q;
  logic signed [PEAK_W-1:0] m_c;

  always_comb begin
    m_c     = mag(PEAK_W'(signed'(sample)), SAMPLE_W, ABS_MODE != 0);
    rec_d_c = rec_q;
    // Strictly-greater update keeps the earliest frame on ties.
    if (en && (load || (m_c > rec_q.peak))) begin
      rec_d_c.peak = m_c;
      rec_d_c.idx  = frame_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rec_q <= '0;
    else     rec_q <= rec_d_c;
  end

endmodule

// File: rtl/axis_window_peak_detector.sv
// Multi-channel windowed peak detector: frames LANES x BEATS samples from an AXIS
// slave, tracks per-channel peaks over WINDOW frames, drains one result beat per channel.
module axis_window_peak_detector
  import peak_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned LANES    = 2,
  parameter int unsigned BEATS    = 2,
  parameter int unsigned WINDOW   = 500,
  parameter int unsigned ABS_MODE = 1
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_areset,
  input  logic [LANES*SAMPLE_W-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [M_TDATA_W-1:0]      m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      overrun,
  output logic                      frame_err
);

  localparam int unsigned NUM_CH   = LANES * BEATS;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [CH_IDX_W-1:0]  ch_idx_q, ch_idx_d;
  logic                 s_tready_q, s_tready_d;
  logic [M_TDATA_W-1:0] m_tdata_q, m_tdata_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tlast_q, m_tlast_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  peak_rec_t            buf_q [NUM_CH];
  peak_rec_t            buf_d [NUM_CH];
  peak_rec_t            rec_d_c [NUM_CH];

  logic acc_c, last_beat_c, bad_c, frm_end_c, win_end_c, upd_c, load_c, hs_c, hs_last_c;

  always_comb begin
    acc_c       = s_axis_tvalid && s_tready_q;
    last_beat_c = (beat_cnt_q == BEAT_W'(BEATS-1));
    bad_c       = acc_c && (s_axis_tlast != last_beat_c);
    frm_end_c   = acc_c && s_axis_tlast && last_beat_c;
    win_end_c   = frm_end_c && (frame_cnt_q == IDX_W'(WINDOW-1));
    upd_c       = acc_c && !bad_c;
    load_c      = (frame_cnt_q == '0);
    hs_c        = m_tvalid_q && m_axis_tready;
    hs_last_c   = hs_c && m_tlast_q;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned B = c / LANES;
    localparam int unsigned K = c % LANES;
    peak_lane_tracker #(
      .SAMPLE_W (SAMPLE_W),
      .ABS_MODE (ABS_MODE)
    ) u_trk (
      .clk       (s_axis_aclk),
      .rst       (s_axis_areset),
      .en        (upd_c && (beat_cnt_q == BEAT_W'(B))),
      .load      (load_c),
      .sample    (s_axis_tdata[K*SAMPLE_W +: SAMPLE_W]),
      .frame_idx (frame_cnt_q),
      .rec_d_c   (rec_d_c[c])
    );
  end

  // Framing counters, result buffer and output FSM next-state.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    ch_idx_d    = ch_idx_q;
    s_tready_d  = 1'b1;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q | bad_c;
    buf_d       = buf_q;

    if (bad_c || frm_end_c) beat_cnt_d = '0;
    else if (acc_c)         beat_cnt_d = beat_cnt_q + BEAT_W'(1);

    if (win_end_c)      frame_cnt_d = '0;
    else if (frm_end_c) frame_cnt_d = frame_cnt_q + IDX_W'(1);

    if (hs_c) begin
      if (hs_last_c) begin
        state_d    = IDLE;
        m_tvalid_d = 1'b0;
        m_tlast_d  = 1'b0;
      end else begin
        ch_idx_d  = ch_idx_q + CH_IDX_W'(1);
        m_tdata_d = pack_beat(buf_q[ch_idx_d], CH_W'(ch_idx_d));
        m_tlast_d = (ch_idx_d == CH_IDX_W'(NUM_CH-1));
      end
    end

    // A window may load the buffer only once the previous drain has finished.
    if (win_end_c) begin
      if ((state_q == IDLE) || hs_last_c) begin
        buf_d      = rec_d_c;
        state_d    = SEND;
        ch_idx_d   = '0;
        m_tdata_d  = pack_beat(rec_d_c[0], '0);
        m_tvalid_d = 1'b1;
        m_tlast_d  = (NUM_CH == 1);
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      ch_idx_q    <= '0;
      s_tready_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      buf_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ch_idx_q    <= ch_idx_d;
      s_tready_q  <= s_tready_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      buf_q       <= buf_d;
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign overrun       = overrun_q;
  assign frame_err     = frame_err_q;

endmodule
